top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port SW, input, 18 bits: slide switches; SW[0]=enable, SW[1]=increase, SW[2]=decrease, SW[17:3] ignored.
REQ-004 SHALL have port HEX0, output, 7 bits: ones digit of duty percent, active-low segments.
REQ-005 SHALL have port HEX1, output, 7 bits: tens digit, same encoding.
REQ-006 SHALL have port HEX2, output, 7 bits: hundreds digit, same encoding.
REQ-007 SHALL have port pwm_out, output, 1 bit: the PWM waveform.
REQ-008 SHALL have parameter STEP, default 10, meaning the duty percent change per button event.
REQ-009 SHALL have parameter PERIOD, default 100, meaning the PWM period in clk cycles.

Function
REQ-010 SHALL pass SW[2:0] through a two-flop synchronizer, then one more register for edge detection.
REQ-011 SHALL flag inc on a synchronized 0->1 transition of SW[1], and dec likewise for SW[2].
REQ-012 SHALL update duty (7-bit register, range 0..100) in the cycle the edge is flagged, so the change is visible 3 clk edges after SW is first sampled high.
REQ-013 SHALL make duty = min(duty+STEP, 100) on inc, saturating with no wrap.
REQ-014 SHALL make duty = max(duty-STEP, 0) on dec, saturating with no wrap below 0.
REQ-015 SHALL leave duty unchanged when inc and dec are flagged in the same cycle.
REQ-016 SHALL ignore inc/dec while synchronized enable=0, retaining duty.
REQ-017 SHALL ignore a held switch after its edge; only a new 0->1 transition produces another step.
REQ-018 SHALL run a free-running counter cnt 0..PERIOD-1 that wraps to 0.
REQ-019 SHALL drive pwm_out = enable AND (cnt < duty), registered; duty 0 gives constant 0, duty 100 gives constant 1.
REQ-020 SHALL apply a duty change at the next cycle's compare, without waiting for period end.
REQ-021 SHALL drive HEX2/HEX1/HEX0 combinationally from duty as decimal hundreds/tens/ones when enable=1, leading zeros shown.
REQ-022 SHALL use 7-segment code bit0=a..bit6=g, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 SHALL blank all three displays (1111111) while enable=0.

Reset
REQ-024 SHALL on rst=1 at a clk edge set duty=0, cnt=0, pwm_out=0 and clear all synchronizer/edge registers to 0.
REQ-025 SHALL ensure a switch already high when rst deasserts produces no step until it returns low and rises again.
REQ-026 SHALL give rst priority over inc/dec in the same cycle.
REQ-027 SHALL let rst mid-operation abort the current PWM period and restart cnt at 0 on the next edge.

Verification
REQ-028 SHALL pass: rst, SW=0 -> HEX2..0 all 1111111, pwm_out=0.
REQ-029 SHALL pass: SW[0]=1 after rst -> HEX2=HEX1=HEX0=1000000 (000), pwm_out constant 0.
REQ-030 SHALL pass: two SW[1] pulses of 2 clk each -> duty 20, HEX1=0100100, HEX0=1000000, pwm_out high 20 of every 100 cycles.
REQ-031 SHALL pass: 12 SW[1] pulses -> duty saturates at 100, HEX2=1111001, pwm_out constant 1; then one SW[2] pulse -> 90.
REQ-032 SHALL pass: SW[1] and SW[2] rising in the same cycle -> duty unchanged; SW[2] pulse at duty 0 -> stays 0.
REQ-033 SHALL pass: SW[0]=0 with SW[1] pulses -> duty unchanged, displays blank; re-enable shows the prior value.

Source files
------------

// File: rtl/top.sv
// Switch-controlled PWM generator with saturating duty percent,
// free-running period counter and three-digit 7-segment readout.
module top #(
  parameter int STEP   = 10,
  parameter int PERIOD = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SW,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic        pwm_out
);

  localparam int CW =
    ($clog2(PERIOD) > 7 ? $clog2(PERIOD) : 7) + 1;
  localparam logic [7:0] STEP_W = 8'(STEP);
  localparam logic [6:0] BLANK  = 7'h7f;

  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;
  logic [1:0]    warm_q, warm_d;
  logic [2:1]    arm_q, arm_d;
  logic [6:0]    duty_q, duty_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;

  logic       en, inc, dec;
  logic [7:0] up, dn;
  logic [6:0] hund, tens, ones;
  logic       unused_sw;

  assign unused_sw = ^SW[17:3];

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    sync1_d = SW[2:0];
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    warm_d  = {warm_q[0], 1'b1};
    // A button only arms once it has been seen low after reset
    arm_d   = arm_q | ({2{warm_q[1]}} & ~sync2_q[2:1]);

    en  = sync2_q[0];
    inc = arm_q[1] & sync2_q[1] & ~prev_q[1];
    dec = arm_q[2] & sync2_q[2] & ~prev_q[2];

    up = {1'b0, duty_q} + STEP_W;
    dn = {1'b0, duty_q} - STEP_W;

    duty_d = duty_q;
    if (en && inc && !dec)
      duty_d = (up > 8'd100) ? 7'd100 : up[6:0];
    else if (en && dec && !inc)
      duty_d = ({1'b0, duty_q} < STEP_W) ? 7'd0 : dn[6:0];

    cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0
                                       : cnt_q + CW'(1);
    pwm_d = en && (cnt_q < CW'(duty_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      arm_q   <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      arm_q   <= arm_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
    end
  end

  always_comb begin
    hund = duty_q / 7'd100;
    tens = (duty_q / 7'd10) % 7'd10;
    ones = duty_q % 7'd10;
    HEX2 = en ? seg(hund[3:0]) : BLANK;
    HEX1 = en ? seg(tens[3:0]) : BLANK;
    HEX0 = en ? seg(ones[3:0]) : BLANK;
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_top.sv
// Randomized bench for the PWM top: a duty/enable model stepped per
// button press predicts the displays and high-time per period.
module tb_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic [6:0]  hex0, hex1, hex2;
  logic        pwm;

  always #5 clk = ~clk;

  top dut (
    .clk     (clk),
    .rst     (rst),
    .SW      (sw),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .pwm_out (pwm)
  );

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  int n_run  = 0;
  int n_fail = 0;
  int duty_m = 0;
  bit en_m   = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_disp(string tag);
    logic [6:0] e2, e1, e0;
    e2 = en_m ? seg_tab[duty_m / 100] : 7'h7f;
    e1 = en_m ? seg_tab[(duty_m / 10) % 10] : 7'h7f;
    e0 = en_m ? seg_tab[duty_m % 10] : 7'h7f;
    check({tag, ".hex2"}, 32'(hex2), 32'(e2));
    check({tag, ".hex1"}, 32'(hex1), 32'(e1));
    check({tag, ".hex0"}, 32'(hex0), 32'(e0));
  endtask

  // Any 100-cycle window at fixed duty holds exactly duty high cycles
  task automatic check_pwm(string tag);
    int h;
    h = 0;
    repeat (100) begin
      @(negedge clk);
      h += int'(pwm);
    end
    check(tag, 32'(h), 32'(en_m ? duty_m : 0));
  endtask

  task automatic pulse(logic [1:0] which, int hold);
    sw[2:1] = which;
    idle(hold);
    sw[2:1] = 2'b00;
    idle(4);
    if (en_m) begin
      if (which == 2'b01)
        duty_m = (duty_m + 10 > 100) ? 100 : duty_m + 10;
      else if (which == 2'b10)
        duty_m = (duty_m < 10) ? 0 : duty_m - 10;
    end
  endtask

  task automatic set_en(bit e);
    sw[0] = e;
    en_m  = e;
    idle(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    duty_m = 0;
    idle(4);
  endtask

  initial begin
    sw  = '0;
    rst = 1'b1;
    idle(3);
    check_disp("rst_blank");
    check("rst_pwm", 32'(pwm), 32'd0);
    rst = 1'b0;
    idle(3);

    set_en(1'b1);
    check_disp("en_zero");
    check_pwm("pwm_zero");

    // Step lands on the third edge after the switch is sampled
    sw[1] = 1'b1;
    idle(2);
    check_disp("lat_before");
    idle(1);
    duty_m = 10;
    check_disp("lat_after");
    idle(6);
    sw[1] = 1'b0;
    idle(4);
    check_disp("held_once");
    pulse(2'b01, 2);
    check_disp("duty20");
    check_pwm("pwm20");

    repeat (12) pulse(2'b01, 2);
    check_disp("sat100");
    check_pwm("pwm100");
    pulse(2'b10, 2);
    check_disp("dec90");

    pulse(2'b11, 2);
    check_disp("both");
    repeat (10) pulse(2'b10, 2);
    check_disp("floor0");

    pulse(2'b01, 2);
    set_en(1'b0);
    pulse(2'b01, 2);
    pulse(2'b01, 2);
    check_disp("dis_blank");
    check_pwm("dis_pwm");
    set_en(1'b1);
    check_disp("reen");

    // A switch already high through reset must not step
    sw[1] = 1'b1;
    do_reset();
    idle(4);
    check_disp("hi_thru_rst");
    sw[1] = 1'b0;
    idle(4);
    pulse(2'b01, 2);
    check_disp("after_rearm");

    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4)
        pulse(2'b01, int'($urandom_range(1, 8)));
      else if (op < 7)
        pulse(2'b10, int'($urandom_range(1, 8)));
      else if (op == 7)
        pulse(2'b11, int'($urandom_range(1, 4)));
      else
        set_en(!en_m);
      check_disp($sformatf("rnd%0d", i));
      if (i % 8 == 7)
        check_pwm($sformatf("rnd_pwm%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
